// File: rtl/demux_frame_loader.sv
// Serial-to-parallel loader that drives a 16-output demux and mirrors each routed bit into a frame register.
// Optional build macro DEMUX_FRAME_PARITY_EN adds frame_parity, expected_parity and parity_err.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOAD  | accepting serial bits; frame under construction
// FULL  | complete frame presented downstream, waiting for frame_ready

module demux_frame_loader #(
    parameter int KEY_LAST  = 15,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_bit,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic        demux_data,
    output logic [3:0]  demux_key,
    output logic        demux_enable,
    output logic [15:0] frame,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [7:0]  frames_done
`ifdef DEMUX_FRAME_PARITY_EN
    ,
    input  logic        expected_parity,
    output logic        frame_parity,
    output logic        parity_err
`endif
);

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX  = 4'(KEY_LAST);
    localparam logic [3:0] START_IDX = MSB_FIRST ? LAST_IDX : 4'd0;
    localparam logic [3:0] TERM_IDX  = MSB_FIRST ? 4'd0 : LAST_IDX;

    state_t     state;
    logic [3:0] count;
    logic       accept;
    logic       terminal;
    logic       consume;

    assign accept   = in_valid & in_ready & ~flush & ~reset;
    assign terminal = accept & (count == TERM_IDX);
    assign consume  = (state == FULL) & frame_ready & ~reset;

    // Demux drive is combinational so the routed bit reaches the demux in the accept cycle.
    assign demux_data   = accept ? in_bit : 1'b0;
    assign demux_key    = count;
    assign demux_enable = accept;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= LOAD;
            count       <= START_IDX;
            frame       <= 16'h0000;
            in_ready    <= 1'b1;
            frame_valid <= 1'b0;
            frames_done <= 8'd0;
        end else begin
            case (state)
                LOAD: begin
                    if (flush) begin
                        count <= START_IDX;
                        frame <= 16'h0000;
                    end else if (accept) begin
                        frame[count] <= in_bit;
                        if (count == TERM_IDX) begin
                            state       <= FULL;
                            count       <= START_IDX;
                            in_ready    <= 1'b0;
                            frame_valid <= 1'b1;
                        end else if (MSB_FIRST) begin
                            count <= count - 4'd1;
                        end else begin
                            count <= count + 4'd1;
                        end
                    end
                end
                FULL: begin
                    // flush is deliberately ignored here: a complete frame is never dropped.
                    if (frame_ready) begin
                        state       <= LOAD;
                        frame       <= 16'h0000;
                        in_ready    <= 1'b1;
                        frame_valid <= 1'b0;
                        frames_done <= frames_done + 8'd1;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

`ifdef DEMUX_FRAME_PARITY_EN
    logic par_acc;

    // Running XOR of accepted bits; latched into frame_parity with the terminal bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            par_acc      <= 1'b0;
            frame_parity <= 1'b0;
        end else begin
            if (terminal) begin
                frame_parity <= par_acc ^ in_bit;
                par_acc      <= 1'b0;
            end else if (accept) begin
                par_acc <= par_acc ^ in_bit;
            end else if ((state == LOAD) && flush) begin
                par_acc <= 1'b0;
            end
            if (consume) begin
                frame_parity <= 1'b0;
            end
        end
    end

    assign parity_err = frame_valid & (frame_parity != expected_parity);
`endif

endmodule
